// File: rtl/link_stat_pkg.sv
// link_stat_pkg: shared snapshot layout, FSM encoding and pack/unpack helpers.
// The CDC consumer uses the same helpers so both ends decode snap_data identically.
package link_stat_pkg;
    localparam int N_CNT  = 4;
    localparam int CNT_W  = 16;
    localparam int SEQ_W  = 8;
    localparam int SNAP_W = SEQ_W + N_CNT * CNT_W;

    typedef enum logic [1:0] {EMPTY, FULL, FULL_PEND} snap_state_t;

    typedef struct packed {
        logic [SEQ_W-1:0]            seq;
        logic [N_CNT-1:0][CNT_W-1:0] cnt;
    } snap_t;

    function automatic logic [SNAP_W-1:0] pack_snap(input logic [SEQ_W-1:0] seq,
                                                    input logic [N_CNT-1:0][CNT_W-1:0] cnt);
        return {seq, cnt};
    endfunction

    function automatic snap_t unpack_snap(input logic [SNAP_W-1:0] d);
        return snap_t'(d);
    endfunction
endpackage

// File: rtl/link_stat_snapshot_sat_counter.sv
// sat_counter: saturating up-counter with a load that restarts it at the current increment.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk_in,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr_load,
    output logic [W-1:0] q
);
    always_ff @(posedge clk_in or posedge rst)
        if (rst) q <= '0;
        else if (clr_load) q <= {{(W-1){1'b0}}, inc};
        else if (inc && q != '1) q <= q + 1'b1;
endmodule

// File: rtl/link_stat_snapshot.sv
// link_stat_snapshot: lossless event counting with periodic/forced sequence-numbered
// snapshots presented on a valid/ready interface towards the stats CDC.
module link_stat_snapshot #(
    parameter int N_CNT    = 4,
    parameter int CNT_W    = 16,
    parameter int SEQ_W    = 8,
    parameter int PERIOD_W = 20
) (
    input  logic                         clk_in,
    input  logic                         rst,
    input  logic [PERIOD_W-1:0]          period,
    input  logic [N_CNT-1:0]             evt,
    input  logic                         force_snap,
    output logic [SEQ_W+N_CNT*CNT_W-1:0] snap_data,
    output logic                         snap_vld,
    input  logic                         snap_rdy,
    output logic [7:0]                   miss_cnt
);
    import link_stat_pkg::*;

    logic [N_CNT-1:0][CNT_W-1:0] cnt;
    logic [PERIOD_W-1:0]         timer, period_q;
    logic [SEQ_W-1:0]            seq;
    snap_state_t                 state, state_nxt;
    logic                        tick, req, acc, capture, miss;

    assign tick     = period != '0 && timer == period - 1'b1;
    assign req      = tick | force_snap;
    assign acc      = snap_vld & snap_rdy;
    assign capture  = (req | state == FULL_PEND) & (state == EMPTY | acc);
    assign miss     = state == FULL_PEND & req & ~acc;
    assign snap_vld = state != EMPTY;

    always_comb
        state_nxt = capture ? FULL : acc ? EMPTY : (state == FULL && req) ? FULL_PEND : state;

    // Capture samples counters before this cycle's increments; the counters reload with evt.
    always_ff @(posedge clk_in or posedge rst)
        if (rst) begin
            state     <= EMPTY;
            seq       <= '0;
            snap_data <= '0;
            timer     <= '0;
            period_q  <= '0;
        end else begin
            state    <= state_nxt;
            period_q <= period;
            timer    <= (period != period_q || tick || period == '0) ? '0 : timer + 1'b1;
            if (capture) begin
                snap_data <= {seq, cnt};
                seq       <= seq + 1'b1;
            end
        end

    for (genvar i = 0; i < N_CNT; i++) begin : g_cnt
        sat_counter #(.W(CNT_W)) u_cnt (
            .clk_in  (clk_in),
            .rst     (rst),
            .inc     (evt[i]),
            .clr_load(capture),
            .q       (cnt[i])
        );
    end

    sat_counter #(.W(8)) u_miss (
        .clk_in  (clk_in),
        .rst     (rst),
        .inc     (miss),
        .clr_load(1'b0),
        .q       (miss_cnt)
    );
endmodule

// File: tb/tb_link_stat_snapshot.sv
// tb_link_stat_snapshot: directed checks of snapshot timing, content, back-pressure and reset.
module tb_link_stat_snapshot;
    logic        clk_in = 0, rst = 1;
    logic [19:0] period = 0, period_b = 0;
    logic [3:0]  evt = 0, evt_b = 0;
    logic        force_snap = 0, snap_rdy = 1, rdy_b = 1;
    logic [71:0] data_a;
    logic [23:0] data_b;
    logic        vld_a, vld_b;
    logic [7:0]  miss_a, miss_b;
    int          checks = 0, errors = 0;

    link_stat_snapshot dut_a (
        .clk_in(clk_in), .rst(rst), .period(period), .evt(evt), .force_snap(force_snap),
        .snap_data(data_a), .snap_vld(vld_a), .snap_rdy(snap_rdy), .miss_cnt(miss_a));

    link_stat_snapshot #(.CNT_W(4)) dut_b (
        .clk_in(clk_in), .rst(rst), .period(period_b), .evt(evt_b), .force_snap(1'b0),
        .snap_data(data_b), .snap_vld(vld_b), .snap_rdy(rdy_b), .miss_cnt(miss_b));

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge clk_in);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1;
        #2;
        cyc(1);
        rst = 0;
    endtask

    task automatic check_a(input string tag, input logic [7:0] seq, input logic [15:0] c0, input logic [15:0] c2);
        check({tag, ".vld"}, vld_a, 1'b1);
        check({tag, ".seq"}, data_a[71:64], seq);
        check({tag, ".c0"}, data_a[15:0], c0);
        check({tag, ".c2"}, data_a[47:32], c2);
    endtask

    initial begin
        // Reset values and periodic snapshots every 10 cycles
        period = 10; evt = 4'b0001; snap_rdy = 1;
        rst = 1;
        cyc(2);
        check("rst.vld", vld_a, 1'b0);
        check("rst.data", data_a, 72'h0);
        check("rst.miss", miss_a, 8'd0);
        rst = 0;
        cyc(10);
        check("t1.idle", vld_a, 1'b0);
        cyc(1);
        check_a("t1.s0", 8'd0, 16'd10, 16'd0);
        cyc(1);
        check("t1.drop", vld_a, 1'b0);
        cyc(9);
        check_a("t1.s1", 8'd1, 16'd10, 16'd0);
        cyc(10);
        check_a("t1.s2", 8'd2, 16'd10, 16'd0);

        // Forced snapshot with period disabled; the capture-cycle event rolls over
        period = 0; evt = 0; snap_rdy = 1;
        do_reset();
        cyc(3);
        evt = 4'b0100;
        cyc(2);
        force_snap = 1;
        cyc(1);
        force_snap = 0; evt = 0;
        check_a("t3.s0", 8'd0, 16'd0, 16'd2);
        cyc(1);
        check("t3.drop", vld_a, 1'b0);
        force_snap = 1;
        cyc(1);
        force_snap = 0;
        check_a("t3.s1", 8'd1, 16'd0, 16'd1);

        // Back-pressure: held snapshot stays stable, merged requests counted
        period = 10; evt = 4'b0001; snap_rdy = 0;
        do_reset();
        cyc(11);
        check_a("t4.s0", 8'd0, 16'd10, 16'd0);
        cyc(10);
        check_a("t4.hold1", 8'd0, 16'd10, 16'd0);
        check("t4.miss0", miss_a, 8'd0);
        cyc(10);
        check("t4.miss1", miss_a, 8'd1);
        cyc(10);
        check_a("t4.hold2", 8'd0, 16'd10, 16'd0);
        check("t4.miss2", miss_a, 8'd2);
        cyc(4);
        snap_rdy = 1;
        cyc(1);
        check_a("t4.s1", 8'd1, 16'd35, 16'd0);
        check("t4.miss_keep", miss_a, 8'd2);
        cyc(1);
        check("t4.drop", vld_a, 1'b0);
        cyc(4);
        check_a("t4.s2", 8'd2, 16'd5, 16'd0);

        // tick and force_snap in the same cycle are one request
        period = 10; evt = 4'b0001; snap_rdy = 1;
        do_reset();
        cyc(10);
        force_snap = 1;
        cyc(1);
        force_snap = 0;
        check_a("t5.s0", 8'd0, 16'd10, 16'd0);
        check("t5.miss", miss_a, 8'd0);
        cyc(1);
        check("t5.single", vld_a, 1'b0);
        cyc(9);
        check_a("t5.s1", 8'd1, 16'd10, 16'd0);

        // Asynchronous reset while FULL_PEND
        period = 10; evt = 4'b0001; snap_rdy = 0;
        do_reset();
        cyc(21);
        check("t6.pend", vld_a, 1'b1);
        rst = 1;
        #1;
        check("t6.async_vld", vld_a, 1'b0);
        check("t6.async_data", data_a, 72'h0);
        period = 5;
        cyc(1);
        rst = 0; snap_rdy = 1;
        cyc(5);
        check("t6.idle", vld_a, 1'b0);
        cyc(1);
        check_a("t6.s0", 8'd0, 16'd5, 16'd0);

        // Saturation with 4-bit counters, then a fresh window
        period_b = 40; evt_b = 4'b0010; rdy_b = 1;
        do_reset();
        cyc(41);
        check("t2.vld", vld_b, 1'b1);
        check("t2.sat", data_b[7:4], 4'd15);
        check("t2.seq0", data_b[23:16], 8'd0);
        cyc(1);
        check("t2.drop", vld_b, 1'b0);
        cyc(8);
        evt_b = 0;
        cyc(31);
        check("t2.vld1", vld_b, 1'b1);
        check("t2.fresh", data_b[7:4], 4'd10);
        check("t2.seq1", data_b[23:16], 8'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/link_stat_snapshot.md
# link_stat_snapshot

Accumulates per-cycle link event strobes (CRC errors, retransmits, and similar) in the clk_in domain. Periodically, or on demand, it captures the counts as a sequence-numbered snapshot and presents it on a valid/ready interface. That interface feeds the din/din_vld/din_rdy side of the multi-bit CDC handshake that carries statistics into the management clock domain. Counting is lossless across snapshots: every event lands in exactly one snapshot, or saturates.

## Interface
Parameters:
- N_CNT, 4, number of event counters
- CNT_W, 16, width of each counter (saturating)
- SEQ_W, 8, snapshot sequence number width
- PERIOD_W, 20, width of the period input

Ports:
- clk_in  in  1  clock; reset rst, asynchronous, active-high; clock clk_in
- rst  in  1  asynchronous active-high reset
- period  in  PERIOD_W  snapshot interval in clk_in cycles; 0 disables periodic snapshots; quasi-static
- evt  in  N_CNT  event strobes, one increment per bit per cycle
- force_snap  in  1  single-cycle request for an immediate snapshot
- snap_data  out  SEQ_W+N_CNT*CNT_W  {seq, cnt[N_CNT-1], ..., cnt[0]}
- snap_vld  out  1  snapshot valid
- snap_rdy  in  1  downstream ready (CDC din_rdy)
- miss_cnt  out  8  saturating count of requests merged while one was already pending

## Operation
- Live counters cnt[i]: increment by evt[i] each cycle; saturate at 2^CNT_W-1.
- Timer: counts 0..period-1 and wraps. tick is asserted when timer==period-1 and period!=0. A change of period resets the timer to 0.
- req = tick | force_snap.
- Output state machine:
  - EMPTY: no snapshot held.
  - FULL: snapshot held, snap_vld=1.
  - FULL_PEND: held, plus one capture request pending.
- Capture occurs when (req or pending) and (state==EMPTY, or snap_vld & snap_rdy this cycle). On capture:
  - snap_data <= {seq, cnt}, using counter values before this cycle's increments.
  - cnt[i] <= evt[i], so this cycle's events go to the next snapshot.
  - seq <= seq+1, wrapping.
- Transitions:
  - EMPTY + capture -> FULL.
  - FULL + accept without capture -> EMPTY.
  - FULL + accept + capture -> FULL (back-to-back).
  - FULL + req without accept -> FULL_PEND.
  - FULL_PEND + accept -> FULL, with the pending capture taken in the same cycle.
  - FULL_PEND + req -> stays FULL_PEND, miss_cnt+1 (saturating at 255).
- While a snapshot is held, snap_data is stable and snap_vld stays asserted until accepted. snap_data never changes without a handshake.
- tick and force_snap in the same cycle count as one request.

## Timing
- Reset values: snap_vld=0, snap_data=0, miss_cnt=0, seq=0, cnt=0, timer=0, state EMPTY.
- Reset mid-operation discards any held or pending snapshot. The first post-reset snapshot carries seq=0.
- Latency: a request in cycle t with state EMPTY gives snap_vld=1 in cycle t+1.
- snap_rdy is used combinationally only in the capture/accept decision; there is no combinational path from snap_rdy to snap_vld or snap_data.
- Accept and capture in the same cycle: the new snapshot is visible at t+1 with no bubble.
- Throughput: at most one snapshot per cycle; in practice bounded by CDC round trip.

## Structure
- Shared package link_stat_pkg:
  - localparam SNAP_W = SEQ_W+N_CNT*CNT_W.
  - typedef enum {EMPTY, FULL, FULL_PEND} snap_state_t.
  - Packing/unpacking functions for snap_data so the CDC consumer decodes identically.
- Sub-module sat_counter (CNT_W, inc, clr_load): one instance per event counter, generated N_CNT times; also reused for miss_cnt with width 8.
- The top level holds the timer, FSM, and output register.

## Test plan
- period=10, evt[0] held 1, snap_rdy=1: snapshots every 10 cycles with cnt[0]=10 and seq 0,1,2,...; the sum over snapshots equals total events.
- CNT_W=4, period=40, evt[1] held 1: snapshot shows cnt[1]=15 (saturated); the next snapshot starts fresh at 10 within its window.
- period=0, force_snap pulse at cycle 5 with evt[2]=1 in cycles 3..5: snap_vld at cycle 6, cnt[2]=2; the cycle-5 event appears in the next snapshot.
- snap_rdy=0 for 35 cycles with period=10: snapshot held stable, state FULL_PEND, miss_cnt=2. On snap_rdy=1 the next snapshot follows with no bubble and seq increments by exactly 1.
- tick and force_snap coincide: one capture, seq +1, miss_cnt unchanged.
- rst asserted while FULL_PEND: snap_vld=0 immediately. After release with period=5, the first snapshot has seq=0 and counts only post-reset events.
